// File: rtl/fake_pcie_pkg.sv
// Shared constants and the AR queue entry type for the fake PCIe read responder.
package fake_pcie_pkg;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Widest ID/address an entry can hold; narrower ports are zero-extended on push.
    localparam int ENTRY_IW = 16;
    localparam int ENTRY_AW = 64;

    typedef struct packed {
        logic [ENTRY_IW-1:0] id;
        logic [ENTRY_AW-1:0] addr;
        logic [7:0]          len;
        logic [1:0]          burst;
        logic                size_ok;
    } ar_entry_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_t;

endpackage

// File: rtl/fake_pcie_ar_fifo.sv
// Outstanding-AR queue: synchronous FIFO of ar_entry_t with same-cycle push and pop.
module fake_pcie_ar_fifo
    import fake_pcie_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  ar_entry_t              wdata_i,
    input  logic                   pop_i,
    output ar_entry_t              rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    ar_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is accepted only when a pop frees the slot that same cycle.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != (PW+1)'(DEPTH)) || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fake_pcie_read_responder.sv
// AXI4 read slave standing in for the host PCIe bridge: queues AR requests and
// returns bursts whose data carries the beat address and beat index.
module fake_pcie_read_responder
    import fake_pcie_pkg::*;
#(
    parameter int DW        = 512,
    parameter int AW        = 64,
    parameter int IW        = 4,
    parameter int DEPTH     = 8,
    parameter int FIX_BEATS = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [AW-1:0]          S_AXI_ARADDR,
    input  logic [IW-1:0]          S_AXI_ARID,
    input  logic [7:0]             S_AXI_ARLEN,
    input  logic [2:0]             S_AXI_ARSIZE,
    input  logic [1:0]             S_AXI_ARBURST,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [DW-1:0]          S_AXI_RDATA,
    output logic [IW-1:0]          S_AXI_RID,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RLAST,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic [31:0]            bursts_done
);

    localparam int              OW         = $clog2(DEPTH) + 1;
    localparam logic [2:0]      SIZE_FULL  = 3'($clog2(DW / 8));
    localparam logic [AW-1:0]   BEAT_BYTES = AW'(DW / 8);
    localparam logic [7:0]      FIX_LEFT   = 8'((FIX_BEATS > 0) ? FIX_BEATS - 1 : 0);

    r_state_t      state_q, state_d;
    logic          rvalid_q, rvalid_d;
    logic [AW-1:0] beat_addr_q, beat_addr_d;
    logic [15:0]   beat_idx_q, beat_idx_d;
    logic [7:0]    beats_left_q, beats_left_d;
    logic [IW-1:0] rid_q, rid_d;
    logic [1:0]    burst_q, burst_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          arready_q, arready_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [31:0]   bursts_done_q, bursts_done_d;

    ar_entry_t     push_entry;
    ar_entry_t     head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [OW-1:0] fifo_count;
    logic [OW-1:0] fifo_count_next;
    logic          fifo_pop;
    logic          ar_hs;
    logic          r_hs;
    logic          last_hs;
    logic          unused_fifo;

    assign ar_hs   = S_AXI_ARVALID && arready_q;
    assign r_hs    = rvalid_q && S_AXI_RREADY;
    assign last_hs = r_hs && (beats_left_q == 8'd0);

    always_comb begin
        push_entry         = '0;
        push_entry.id      = ENTRY_IW'(S_AXI_ARID);
        push_entry.addr    = ENTRY_AW'(S_AXI_ARADDR);
        push_entry.len     = S_AXI_ARLEN;
        push_entry.burst   = S_AXI_ARBURST;
        push_entry.size_ok = (S_AXI_ARSIZE == SIZE_FULL);
    end

    fake_pcie_ar_fifo #(
        .DEPTH(DEPTH)
    ) u_ar_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push_i (ar_hs),
        .wdata_i(push_entry),
        .pop_i  (fifo_pop),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    // Upper ID/address bits of an entry are always zero; full is implied by the registered ARREADY.
    assign unused_fifo = ^{head.id, head.addr, fifo_full};

    always_comb begin
        state_d      = state_q;
        rvalid_d     = rvalid_q;
        beat_addr_d  = beat_addr_q;
        beat_idx_d   = beat_idx_q;
        beats_left_d = beats_left_q;
        rid_d        = rid_q;
        burst_d      = burst_q;
        rresp_d      = rresp_q;
        fifo_pop     = 1'b0;

        case (state_q)
            R_IDLE: begin
                fifo_pop = !fifo_empty;
            end
            R_BURST: begin
                if (r_hs) begin
                    if (beats_left_q == 8'd0) begin
                        fifo_pop = !fifo_empty;
                        if (fifo_empty) begin
                            state_d  = R_IDLE;
                            rvalid_d = 1'b0;
                        end
                    end else begin
                        beat_idx_d   = beat_idx_q + 16'd1;
                        beats_left_d = beats_left_q - 8'd1;
                        case (burst_q)
                            BURST_FIXED:            beat_addr_d = beat_addr_q;
                            BURST_INCR, BURST_WRAP: beat_addr_d = beat_addr_q + BEAT_BYTES;
                            default:                beat_addr_d = beat_addr_q + BEAT_BYTES;
                        endcase
                    end
                end
            end
            default: begin
                state_d  = R_IDLE;
                rvalid_d = 1'b0;
            end
        endcase

        // Loading from IDLE or straight after a final beat keeps bursts back-to-back.
        if (fifo_pop) begin
            state_d      = R_BURST;
            rvalid_d     = 1'b1;
            beat_addr_d  = head.addr[AW-1:0];
            beat_idx_d   = 16'd0;
            beats_left_d = (FIX_BEATS > 0) ? FIX_LEFT : head.len;
            rid_d        = head.id[IW-1:0];
            burst_d      = head.burst;
            rresp_d      = head.size_ok ? RRESP_OKAY : RRESP_SLVERR;
        end
    end

    always_comb begin
        fifo_count_next = fifo_count + OW'(ar_hs) - OW'(fifo_pop);
        arready_d       = (fifo_count_next != OW'(DEPTH));
        outstanding_d   = outstanding_q + OW'(ar_hs) - OW'(last_hs);
        bursts_done_d   = bursts_done_q + 32'(last_hs);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= R_IDLE;
            rvalid_q      <= 1'b0;
            beat_addr_q   <= '0;
            beat_idx_q    <= '0;
            beats_left_q  <= '0;
            rid_q         <= '0;
            burst_q       <= BURST_FIXED;
            rresp_q       <= RRESP_OKAY;
            arready_q     <= 1'b0;
            outstanding_q <= '0;
            bursts_done_q <= '0;
        end else begin
            state_q       <= state_d;
            rvalid_q      <= rvalid_d;
            beat_addr_q   <= beat_addr_d;
            beat_idx_q    <= beat_idx_d;
            beats_left_q  <= beats_left_d;
            rid_q         <= rid_d;
            burst_q       <= burst_d;
            rresp_q       <= rresp_d;
            arready_q     <= arready_d;
            outstanding_q <= outstanding_d;
            bursts_done_q <= bursts_done_d;
        end
    end

    always_comb begin
        S_AXI_RDATA              = '0;
        S_AXI_RDATA[DW-1 -: AW]  = beat_addr_q;
        S_AXI_RDATA[15:0]        = beat_idx_q;
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rvalid_q && (beats_left_q == 8'd0);
    assign outstanding   = outstanding_q;
    assign bursts_done   = bursts_done_q;

endmodule
